// File: rtl/spi_mnrch_param.sv
// spi_mnrch_param: parametrised SPI master.
// Each accepted snd runs one full-duplex frame of DATA_W bits, MSB first, to
// one of NUM_SS slaves in the {CPOL,CPHA} mode latched at accept. Half-period
// of SCLK is H = 2^(DIV_W-1) clk. Every output is registered.
module spi_mnrch_param #(
  parameter int          DATA_W     = 16,
  parameter int          DIV_W      = 5,
  parameter int          NUM_SS     = 1,
  parameter int          SS_IDX_W   = 3,
  parameter logic [1:0]  RESET_MODE = 2'b11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snd,
  input  logic [DATA_W-1:0]   cmd,
  input  logic [1:0]          mode,
  input  logic [SS_IDX_W-1:0] ss_sel,
  input  logic                MISO,
  output logic                SCLK,
  output logic                MOSI,
  output logic [NUM_SS-1:0]   SS_n,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   resp
);

  localparam int H   = 1 << (DIV_W - 1);
  // Frame offset counter covers DATA_W*2H + H with DATA_W <= 32.
  localparam int T_W = DIV_W + 6;
  localparam int B_W = $clog2(DATA_W + 1);

  localparam logic [T_W-1:0]   T_2H    = T_W'(2 * H);
  localparam logic [T_W-1:0]   T_SHEND = T_W'(DATA_W * 2 * H);
  localparam logic [T_W-1:0]   T_END   = T_W'(DATA_W * 2 * H + H);
  // Sample events fall 2 clk after the sampling edge, expressed as a phase
  // within the 2H-clock bit period.
  localparam logic [DIV_W-1:0] PH_CPHA0 = DIV_W'(H + 2);
  localparam logic [DIV_W-1:0] PH_CPHA1 = DIV_W'(2);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(DATA_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] BACKP = 2'd2;

  logic [1:0]        state;
  logic [T_W-1:0]    t_q;
  logic [B_W-1:0]    bcnt;
  logic [DATA_W-1:0] shift_reg;
  logic [1:0]        mode_q;
  logic              sclk_q;
  logic [NUM_SS-1:0] ss_q;
  logic              busy_q;
  logic              done_q;

  logic [T_W-1:0]    t_nxt;
  logic              sample_hit;
  logic              sclk_nxt;
  logic [NUM_SS-1:0] ss_dec;
  logic              sel_ok;

  assign SCLK = sclk_q;
  assign MOSI = shift_reg[DATA_W-1];
  assign SS_n = ss_q;
  assign busy = busy_q;
  assign done = done_q;
  assign resp = shift_reg;

  // Slave-select decode; out-of-range indices fall back to slave 0.
  always_comb begin
    ss_dec = '1;
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SS_IDX_W'(i)) begin
        ss_dec[i] = 1'b0;
        sel_ok    = 1'b1;
      end
    end
    if (!sel_ok) ss_dec[0] = 1'b0;
  end

  // Timing decode from the frame offset of the coming cycle: SCLK sits at
  // ~CPOL in the second half of each bit; sample events align to the edge
  // chosen by CPHA (for CPHA=1 the phase-2 slot of bit -1 is skipped).
  always_comb begin
    t_nxt      = t_q + 1'b1;
    sclk_nxt   = mode_q[1] ^ ((t_nxt < T_SHEND) && t_nxt[DIV_W-1]);
    sample_hit = (state == SHIFT) &&
                 (t_nxt[DIV_W-1:0] == (mode_q[0] ? PH_CPHA1 : PH_CPHA0)) &&
                 (!mode_q[0] || (t_nxt >= T_2H));
  end

  // Frame sequencer: accept, shift DATA_W bits, back-porch, release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      t_q       <= '0;
      bcnt      <= '0;
      shift_reg <= '0;
      mode_q    <= RESET_MODE;
      sclk_q    <= RESET_MODE[1];
      ss_q      <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snd) begin
            shift_reg <= cmd;
            mode_q    <= mode;
            sclk_q    <= mode[1];
            ss_q      <= ss_dec;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            t_q       <= '0;
            bcnt      <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT, BACKP: begin
          t_q    <= t_nxt;
          sclk_q <= sclk_nxt;
          if (sample_hit) begin
            shift_reg <= {shift_reg[DATA_W-2:0], MISO};
            bcnt      <= bcnt + 1'b1;
            if (bcnt == B_LAST) state <= BACKP;
          end
          if (t_nxt == T_END) begin
            ss_q   <= '1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Directed bench for spi_mnrch_param: a 16-bit / 4-slave instance for the
// mode, slave-select, ignore and reset cases, and an 8-bit / H=4 instance
// for back-to-back framing.
module tb_spi_mnrch_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snd;
  logic [15:0] cmd;
  logic [1:0]  mode;
  logic [2:0]  ss_sel;
  logic        miso;
  logic        sclk, mosi, busy, done;
  logic [3:0]  ss_n;
  logic [15:0] resp;

  logic        snd8;
  logic [7:0]  cmd8;
  logic        sclk8, mosi8, busy8, done8;
  logic [0:0]  ss8;
  logic [7:0]  resp8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spi_mnrch_param #(.DATA_W(16), .DIV_W(5), .NUM_SS(4), .SS_IDX_W(3),
                    .RESET_MODE(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .snd(snd), .cmd(cmd), .mode(mode),
    .ss_sel(ss_sel), .MISO(miso), .SCLK(sclk), .MOSI(mosi), .SS_n(ss_n),
    .busy(busy), .done(done), .resp(resp));

  spi_mnrch_param #(.DATA_W(8), .DIV_W(3), .NUM_SS(1), .SS_IDX_W(3),
                    .RESET_MODE(2'b11)) dut8 (
    .clk(clk), .rst_n(rst_n), .snd(snd8), .cmd(cmd8), .mode(2'b00),
    .ss_sel(3'd0), .MISO(mosi8), .SCLK(sclk8), .MOSI(mosi8), .SS_n(ss8),
    .busy(busy8), .done(done8), .resp(resp8));

  // MISO source: 0 = mode-3 slave model, 1 = tied high, 2 = loopback.
  int          msrc = 0;
  logic        miso_slv = 1'b0;
  logic [15:0] slv_data = '0;
  int          k = 0;
  assign miso = (msrc == 0) ? miso_slv : (msrc == 1) ? 1'b1 : mosi;

  // Mode-3 slave: presents the next bit on each leading (falling) edge.
  always @(negedge sclk) begin
    if (ss_n != 4'hF && k < 16) begin
      miso_slv = slv_data[15-k];
      k++;
    end
  end

  // Frame monitor: SS-low length, SCLK edges inside the frame, MOSI at rises.
  logic        ps = 1'b1, pss_lo = 1'b0;
  int          lowcnt = 0, rises = 0, falls = 0;
  logic [15:0] mcap = '0;
  always @(negedge clk) begin
    if (ss_n != 4'hF) begin
      if (!pss_lo) begin
        lowcnt = 1; rises = 0; falls = 0; mcap = '0;
      end else begin
        lowcnt++;
        if (!ps && sclk) begin rises++; mcap = {mcap[14:0], mosi}; end
        if (ps && !sclk) falls++;
      end
    end
    ps     = sclk;
    pss_lo = (ss_n != 4'hF);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic frame(input logic [15:0] c, input logic [1:0] m, input logic [2:0] s);
    @(negedge clk);
    cmd = c; mode = m; ss_sel = s; snd = 1'b1;
    @(negedge clk);
    snd = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int lowlen, gap;
    rst_n = 1'b0; snd = 1'b0; cmd = '0; mode = 2'b11; ss_sel = '0;
    snd8 = 1'b0; cmd8 = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_ss",   32'(ss_n), 32'hF);
    chk("rst_flag", {30'd0, busy, done}, 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_line", {30'd0, sclk, mosi}, 32'b10);
    rst_n = 1'b1;

    // Mode 3, slave 2, slave model returns 3C5A.
    msrc = 0; slv_data = 16'h3C5A; k = 0;
    frame(16'hA5C3, 2'b11, 3'd2);
    chk("m3_busy", 32'(busy), 32'd1);
    chk("m3_ss",   32'(ss_n), 32'b1011);
    wait_done("m3_timeout");
    chk("m3_resp",  32'(resp), 32'h3C5A);
    chk("m3_len",   32'(lowcnt), 32'd528);
    chk("m3_rises", 32'(rises), 32'd16);
    chk("m3_mosi",  32'(mcap), 32'hA5C3);
    chk("m3_ssoff", 32'(ss_n), 32'hF);
    chk("m3_busy0", 32'(busy), 32'd0);

    // Mode 0, MISO tied high.
    msrc = 1;
    frame(16'h8001, 2'b00, 3'd0);
    chk("m0_idle", {30'd0, sclk, mosi}, 32'b01);
    chk("m0_ss",   32'(ss_n), 32'b1110);
    wait_done("m0_timeout");
    chk("m0_resp", 32'(resp), 32'hFFFF);
    chk("m0_len",  32'(lowcnt), 32'd528);
    chk("m0_mosi", 32'(mcap), 32'h8001);

    // Modes 1 and 2 loopback; ss_sel=5 is out of range -> slave 0.
    msrc = 2;
    frame(16'h1234, 2'b01, 3'd5);
    chk("m1_ss", 32'(ss_n), 32'b1110);
    wait_done("m1_timeout");
    chk("m1_resp",  32'(resp), 32'h1234);
    chk("m1_edges", {rises[15:0], falls[15:0]}, {16'd16, 16'd16});
    chk("m1_sclk",  32'(sclk), 32'd0);
    frame(16'h1234, 2'b10, 3'd1);
    chk("m2_ss", 32'(ss_n), 32'b1101);
    wait_done("m2_timeout");
    chk("m2_resp",  32'(resp), 32'h1234);
    chk("m2_edges", {rises[15:0], falls[15:0]}, {16'd16, 16'd16});
    chk("m2_sclk",  32'(sclk), 32'd1);

    // snd pulse mid-frame is ignored.
    frame(16'hBEEF, 2'b11, 3'd0);
    repeat (99) @(negedge clk);
    cmd = 16'h0000; mode = 2'b00; snd = 1'b1;
    @(negedge clk);
    snd = 1'b0;
    wait_done("ign_timeout");
    chk("ign_resp", 32'(resp), 32'hBEEF);
    chk("ign_len",  32'(lowcnt), 32'd528);

    // Asynchronous reset at t=300 of a mode-0 frame.
    frame(16'h1357, 2'b00, 3'd3);
    repeat (300) @(negedge clk);
    chk("pre_rst_sclk", 32'(sclk), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_ss",   32'(ss_n), 32'hF);
    chk("ar_flag", {30'd0, busy, done}, 32'd0);
    chk("ar_resp", 32'(resp), 32'd0);
    chk("ar_sclk", 32'(sclk), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 8-bit, H=4, snd held high: 68-clk frames with one idle cycle.
    @(negedge clk);
    snd8 = 1'b1;
    gap = 0;
    while (ss8[0] && gap < 200) begin @(negedge clk); gap++; end
    chk("b2b_start", 32'(gap < 200), 32'd1);
    for (int f = 0; f < 2; f++) begin
      lowlen = 0;
      while (!ss8[0] && lowlen < 200) begin lowlen++; @(negedge clk); end
      chk("b2b_len", 32'(lowlen), 32'd68);
      chk("b2b_done", 32'(done8), 32'd1);
      chk("b2b_resp", 32'(resp8), 32'h5A);
      gap = 0;
      while (ss8[0] && gap < 200) begin gap++; @(negedge clk); end
      chk("b2b_gap", 32'(gap), 32'd1);
      chk("b2b_reacc", 32'(done8), 32'd0);
    end
    snd8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
